// File: rtl/rotary_pkg.sv
// Constants shared by the rotary encoder front end, position tracker and display stages.
package rotary_pkg;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int unsigned DEFAULT_N_POS        = 8;
  localparam int unsigned DEFAULT_POS_W        = 3;
  localparam int unsigned DEFAULT_ACCEL_WINDOW = 2500000;

endpackage

// File: rtl/rotary_position_tracker_if.sv
// Step input and position/LED output bundle of the rotary position tracker.
interface rotary_position_tracker_if
  import rotary_pkg::*;
#(
  parameter int unsigned N_POS = DEFAULT_N_POS,
  parameter int unsigned POS_W = DEFAULT_POS_W
);

  logic             rotary_event;
  logic             rotary_left;
  logic             clear;
  logic [POS_W-1:0] position;
  logic [N_POS-1:0] led;
  logic             step_valid;
  logic             step_left;

  modport master (
    output rotary_event, rotary_left, clear,
    input  position, led, step_valid, step_left
  );

  modport slave (
    input  rotary_event, rotary_left, clear,
    output position, led, step_valid, step_left
  );

endinterface

// File: rtl/pos_step_calc.sv
// Combinational next-position calculator: adds or subtracts a step, then wraps or clamps.
module pos_step_calc
  import rotary_pkg::*;
#(
  parameter int unsigned N_POS = DEFAULT_N_POS,
  parameter int unsigned POS_W = DEFAULT_POS_W,
  parameter bit          WRAP  = 1'b1
) (
  input  logic [POS_W-1:0] pos_i,
  input  logic [POS_W-1:0] step_i,
  input  logic             dir_i,
  output logic [POS_W-1:0] pos_o
);

  localparam logic [POS_W:0] NPosW  = (POS_W + 1)'(N_POS);
  localparam logic [POS_W:0] NPosM1 = NPosW - 1'b1;

  logic [POS_W:0] sum;
  logic [POS_W:0] diff;
  logic [POS_W:0] res;
  logic           borrow;

  always_comb begin
    sum    = {1'b0, pos_i} + {1'b0, step_i};
    diff   = {1'b0, pos_i} - {1'b0, step_i};
    borrow = step_i > pos_i;
    res    = {1'b0, pos_i};
    if (dir_i == DIR_LEFT) begin
      if (sum >= NPosW) begin
        res = WRAP ? (sum - NPosW) : NPosM1;
      end else begin
        res = sum;
      end
    end else begin
      // A negative difference is brought back into range by adding N_POS.
      if (borrow) begin
        res = WRAP ? (diff + NPosW) : '0;
      end else begin
        res = diff;
      end
    end
    pos_o = POS_W'(res);
  end

endmodule

// File: rtl/rotary_position_tracker.sv
// Bounded rotary position counter with one-hot LED bar and step strobe.
// Optional step acceleration is enabled by defining ROTARY_ACCEL_EN.
module rotary_position_tracker
  import rotary_pkg::*;
#(
  parameter int unsigned N_POS        = DEFAULT_N_POS,
  parameter int unsigned POS_W        = DEFAULT_POS_W,
  parameter int unsigned INIT_POS     = 0,
  parameter bit          WRAP         = 1'b1,
  parameter int unsigned ACCEL_WINDOW = DEFAULT_ACCEL_WINDOW,
  parameter int unsigned ACCEL_STEP   = 2
) (
  input logic                      clk,
  input logic                      reset,
  rotary_position_tracker_if.slave bus
);

  if (N_POS < 2 || N_POS > 256 || (1 << POS_W) < N_POS || INIT_POS >= N_POS) begin : g_bad_pos
    $error("rotary_position_tracker: inconsistent N_POS/POS_W/INIT_POS");
  end
  if (ACCEL_STEP < 1 || ACCEL_STEP >= N_POS || ACCEL_WINDOW < 1) begin : g_bad_accel
    $error("rotary_position_tracker: inconsistent ACCEL_STEP/ACCEL_WINDOW");
  end

  localparam logic [POS_W-1:0] InitPos = POS_W'(INIT_POS);
  localparam logic [N_POS-1:0] LedOne  = N_POS'(1);
  localparam logic [N_POS-1:0] InitLed = LedOne << INIT_POS;

  logic             event_q, event_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [N_POS-1:0] led_q, led_d;
  logic             step_valid_q, step_valid_d;
  logic             step_left_q, step_left_d;

  logic             accept;
  logic [POS_W-1:0] step;
  logic [POS_W-1:0] calc_pos;

  assign accept = bus.rotary_event & ~event_q;

`ifdef ROTARY_ACCEL_EN
  localparam int unsigned    GapW   = $clog2(ACCEL_WINDOW + 1);
  localparam logic [GapW-1:0] GapMax = GapW'(ACCEL_WINDOW);

  logic [GapW-1:0] gap_q, gap_d;

  // Fast repeated turns in the same direction move by the larger step.
  assign step = ((gap_q < GapMax) && (bus.rotary_left == step_left_q)) ?
                POS_W'(ACCEL_STEP) : POS_W'(1);

  always_comb begin
    gap_d = (gap_q == GapMax) ? gap_q : gap_q + 1'b1;
    if (bus.clear) begin
      gap_d = GapMax;
    end else if (accept) begin
      gap_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q <= GapMax;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  assign step = POS_W'(1);
`endif

  pos_step_calc #(
    .N_POS (N_POS),
    .POS_W (POS_W),
    .WRAP  (WRAP)
  ) u_pos_step_calc (
    .pos_i  (pos_q),
    .step_i (step),
    .dir_i  (bus.rotary_left),
    .pos_o  (calc_pos)
  );

  always_comb begin
    event_d      = bus.rotary_event;
    pos_d        = pos_q;
    led_d        = led_q;
    step_valid_d = 1'b0;
    step_left_d  = step_left_q;
    // Clear wins over a simultaneous accept; the edge register still tracks the input.
    if (bus.clear) begin
      pos_d = InitPos;
      led_d = InitLed;
    end else if (accept) begin
      pos_d        = calc_pos;
      led_d        = LedOne << calc_pos;
      step_valid_d = 1'b1;
      step_left_d  = bus.rotary_left;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      event_q      <= 1'b1;
      pos_q        <= InitPos;
      led_q        <= InitLed;
      step_valid_q <= 1'b0;
      step_left_q  <= 1'b0;
    end else begin
      event_q      <= event_d;
      pos_q        <= pos_d;
      led_q        <= led_d;
      step_valid_q <= step_valid_d;
      step_left_q  <= step_left_d;
    end
  end

  assign bus.position   = pos_q;
  assign bus.led        = led_q;
  assign bus.step_valid = step_valid_q;
  assign bus.step_left  = step_left_q;

endmodule

// File: tb/tb_rotary_position_tracker.sv
// Bench for rotary_position_tracker: a wrapping and a saturating instance share one stimulus
// stream and are checked every cycle against an arithmetic reference model.
module tb_rotary_position_tracker;

  localparam int N       = 8;
  localparam int INIT    = 3;
  localparam int WINDOW  = 100;
  localparam int ASTEP   = 2;
`ifdef ROTARY_ACCEL_EN
  localparam bit ACCEL   = 1'b1;
`else
  localparam bit ACCEL   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ev  = 1'b0;
  logic lf  = 1'b0;
  logic clr = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_pos_w, m_pos_s, m_gap;
  bit m_prev, m_sv, m_sl;

  always #5 clk = ~clk;

  rotary_position_tracker_if #(.N_POS(N), .POS_W(3)) bw ();
  rotary_position_tracker_if #(.N_POS(N), .POS_W(3)) bs ();

  assign bw.rotary_event = ev;
  assign bw.rotary_left  = lf;
  assign bw.clear        = clr;
  assign bs.rotary_event = ev;
  assign bs.rotary_left  = lf;
  assign bs.clear        = clr;

  rotary_position_tracker #(
    .N_POS(N), .POS_W(3), .INIT_POS(INIT), .WRAP(1'b1),
    .ACCEL_WINDOW(WINDOW), .ACCEL_STEP(ASTEP)
  ) dut_w (
    .clk   (clk),
    .reset (rst),
    .bus   (bw)
  );

  rotary_position_tracker #(
    .N_POS(N), .POS_W(3), .INIT_POS(INIT), .WRAP(1'b0),
    .ACCEL_WINDOW(WINDOW), .ACCEL_STEP(ASTEP)
  ) dut_s (
    .clk   (clk),
    .reset (rst),
    .bus   (bs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int move(int p, bit left, bit wrap, int s);
    int r;
    r = left ? p + s : p - s;
    if (wrap) return (r + N) % N;
    if (r < 0) return 0;
    if (r > N - 1) return N - 1;
    return r;
  endfunction

  // One clock: model applies the inputs seen at the edge, then both DUTs are compared.
  task automatic tick();
    bit acc;
    int s;
    logic [7:0] led_w, led_s;
    @(posedge clk);
    if (rst) begin
      m_pos_w = INIT; m_pos_s = INIT; m_sv = 0; m_sl = 0; m_prev = 1; m_gap = WINDOW;
    end else begin
      acc    = ev && !m_prev;
      m_prev = ev;
      if (clr) begin
        m_pos_w = INIT; m_pos_s = INIT; m_sv = 0; m_gap = WINDOW;
      end else if (acc) begin
        s = (ACCEL && m_gap < WINDOW && lf == m_sl) ? ASTEP : 1;
        m_pos_w = move(m_pos_w, lf, 1'b1, s);
        m_pos_s = move(m_pos_s, lf, 1'b0, s);
        m_sv = 1; m_sl = lf; m_gap = 0;
      end else begin
        m_sv = 0;
        if (m_gap < WINDOW) m_gap++;
      end
    end
    #1;
    led_w = 8'd1 << m_pos_w;
    led_s = 8'd1 << m_pos_s;
    chk("w_position", 32'(bw.position), 32'(m_pos_w));
    chk("w_led", 32'(bw.led), 32'(led_w));
    chk("w_step_valid", 32'(bw.step_valid), 32'(m_sv));
    chk("w_step_left", 32'(bw.step_left), 32'(m_sl));
    chk("s_position", 32'(bs.position), 32'(m_pos_s));
    chk("s_led", 32'(bs.led), 32'(led_s));
    chk("s_step_valid", 32'(bs.step_valid), 32'(m_sv));
    chk("s_step_left", 32'(bs.step_left), 32'(m_sl));
  endtask

  task automatic pulse(input bit left);
    ev = 1'b1; lf = left;
    tick();
    ev = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int svc;
    // Reset with event held high across release: no step may be counted.
    rst = 1'b1; ev = 1'b1;
    idle(3);
    chk("reset_pos", 32'(bw.position), 32'd3);
    chk("reset_led", 32'(bw.led), 32'h08);
    chk("reset_sv", 32'(bw.step_valid), 32'd0);
    rst = 1'b0;
    idle(5);
    chk("held_through_reset", 32'(bw.position), 32'd3);
    ev = 1'b0;
    idle(3);

    // Four left pulses, 3 -> 4,5,6,7 with one-cycle strobes.
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1);
      chk("left_pos", 32'(bw.position), 32'(4 + i));
      chk("left_led", 32'(bw.led), 32'(8'h10 << i));
      chk("left_sv", 32'(bw.step_valid), 32'd1);
      tick();
      chk("left_sv_drop", 32'(bw.step_valid), 32'd0);
      idle(10);
    end

    // Wrap vs. saturate at the top.
    pulse(1'b1);
    chk("wrap_up_pos", 32'(bw.position), 32'd0);
    chk("wrap_up_led", 32'(bw.led), 32'h01);
    chk("sat_up_pos", 32'(bs.position), 32'd7);
    chk("sat_up_sv", 32'(bs.step_valid), 32'd1);
    idle(10);
    pulse(1'b0);
    chk("wrap_down_pos", 32'(bw.position), 32'd7);
    chk("sat_down_pos", 32'(bs.position), 32'd6);
    idle(10);

    // Back to 3 via clear, then down to 0 and once more.
    clr = 1'b1; tick(); clr = 1'b0; idle(2);
    for (int i = 0; i < 3; i++) begin pulse(1'b0); idle(10); end
    chk("down_to_zero_w", 32'(bw.position), 32'd0);
    pulse(1'b0);
    chk("wrap_below_zero", 32'(bw.position), 32'd7);
    chk("sat_below_zero", 32'(bs.position), 32'd0);
    chk("sat_below_zero_sv", 32'(bs.step_valid), 32'd1);
    idle(10);

    // Event held 20 cycles counts once.
    ev = 1'b1; lf = 1'b1; svc = 0;
    for (int i = 0; i < 20; i++) begin tick(); svc += int'(bw.step_valid); end
    ev = 1'b0;
    idle(3);
    chk("held_one_step_cnt", 32'(svc), 32'd1);
    chk("held_one_step_pos", 32'(bs.position), 32'd1);
    idle(5);

    // Clear coincident with a pulse discards it, no retrigger afterwards.
    ev = 1'b1; lf = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clear_pos", 32'(bw.position), 32'd3);
    chk("clear_sv", 32'(bw.step_valid), 32'd0);
    tick();
    ev = 1'b0;
    chk("after_clear_sv", 32'(bw.step_valid), 32'd0);
    idle(4);
    chk("after_clear_pos", 32'(bs.position), 32'd3);

    // Reset one cycle after an accept.
    pulse(1'b1);
    rst = 1'b1;
    tick();
    chk("mid_reset_pos", 32'(bw.position), 32'd3);
    chk("mid_reset_sv", 32'(bw.step_valid), 32'd0);
    rst = 1'b0;
    idle(3);

    // Acceleration pattern: pulses at t=0,50,90,300, then a reversal 10 cycles later.
    clr = 1'b1; tick(); clr = 1'b0;
    pulse(1'b1); idle(49);
    pulse(1'b1); idle(39);
    pulse(1'b1);
`ifdef ROTARY_ACCEL_EN
    chk("accel_w_pos", 32'(bw.position), 32'd0);
    chk("accel_s_pos", 32'(bs.position), 32'd7);
`else
    chk("noaccel_w_pos", 32'(bw.position), 32'd6);
`endif
    idle(209);
    pulse(1'b1); idle(9);
    pulse(1'b0);
`ifdef ROTARY_ACCEL_EN
    chk("accel_rev_w", 32'(bw.position), 32'd0);
    chk("accel_rev_s", 32'(bs.position), 32'd6);
`else
    chk("noaccel_rev_w", 32'(bw.position), 32'd6);
`endif
    idle(3);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      ev  = ($urandom_range(0, 9) < 4);
      lf  = $urandom_range(0, 1) == 1;
      clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
